operand_forward_unit: RTL

- Parametrised successor to the two-channel ID-stage operand bypass.
- Supports NUM_RD_CH read channels and NUM_STAGES in-order pipeline write-back stages, with youngest-wins priority.
- Adds x0 suppression, not-yet-ready producers (load-use) detection, and a per-register scoreboard for long-latency units (divider, LSU miss). Raises id_stall instead of forwarding stale data.
- Sits between decode, the register file read ports and the EX/MEM/WB destination buses.

---
 rtl/operand_forward_unit_pkg.sv | 35 +++
 rtl/operand_forward_unit_scoreboard.sv | 69 ++++++
 rtl/operand_forward_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/operand_forward_unit_pkg.sv
// Shared types and helpers for the ID-stage operand forwarding unit.
package operand_forward_unit_pkg;

    localparam int RA_W_DEF    = 5;
    localparam int XLEN_DEF    = 32;
    localparam int MAX_STAGES  = 16;
    localparam int STAGE_IDX_W = 4;

    typedef enum logic [2:0] {
        SRC_ZERO  = 3'd0,
        SRC_STAGE = 3'd1,
        SRC_LAT   = 3'd2,
        SRC_RF    = 3'd3,
        SRC_STALL = 3'd4
    } fwd_src_e;

    typedef struct packed {
        logic                   found;
        logic [STAGE_IDX_W-1:0] idx;
    } stage_sel_t;

    // Lowest-index (youngest) matching stage wins.
    function automatic stage_sel_t stage_select(input logic [MAX_STAGES-1:0] hit);
        stage_sel_t sel;
        sel = '0;
        for (int s = MAX_STAGES - 1; s >= 0; s--) begin
            if (hit[s]) begin
                sel.found = 1'b1;
                sel.idx   = STAGE_IDX_W'(s);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/operand_forward_unit_scoreboard.sv
// Per-register outstanding-count scoreboard for long-latency producers.
module fwd_scoreboard
    import operand_forward_unit_pkg::*;
#(
    parameter int RA_W     = RA_W_DEF,
    parameter int SB_CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 lat_issue_valid,
    input  logic [RA_W-1:0]      lat_issue_addr,
    output logic                 lat_issue_ready,
    input  logic                 lat_done_valid,
    input  logic [RA_W-1:0]      lat_done_addr,
    output logic [(1<<RA_W)-1:0] pending,
    output logic                 sb_err
);

    localparam int NREG = 1 << RA_W;

    logic [NREG-1:0] at_max;
    logic            issue_acc;
    logic            done_acc;
    logic            same_addr;
    logic            err_set;

    assign pending[0] = 1'b0;
    assign at_max[0]  = 1'b0;

    assign lat_issue_ready = !at_max[lat_issue_addr];
    assign issue_acc = lat_issue_valid && lat_issue_ready && (lat_issue_addr != '0);
    assign done_acc  = lat_done_valid && (lat_done_addr != '0);
    // An issue and a return on the same register cancel out, even if the issue itself was refused.
    assign same_addr = lat_issue_valid && lat_done_valid &&
                       (lat_issue_addr == lat_done_addr) && (lat_issue_addr != '0);
    assign err_set   = (lat_issue_valid && !lat_issue_ready) ||
                       (done_acc && !same_addr && !pending[lat_done_addr]);

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        logic [SB_CNT_W-1:0] cnt_q;
        logic                inc;
        logic                dec;

        assign inc = issue_acc && !same_addr && (lat_issue_addr == RA_W'(r));
        assign dec = done_acc && !same_addr && (lat_done_addr == RA_W'(r)) && (cnt_q != '0);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else if (inc) begin
                cnt_q <= cnt_q + SB_CNT_W'(1);
            end else if (dec) begin
                cnt_q <= cnt_q - SB_CNT_W'(1);
            end
        end

        assign pending[r] = (cnt_q != '0);
        assign at_max[r]  = (cnt_q == {SB_CNT_W{1'b1}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_err <= 1'b0;
        end else if (err_set) begin
            sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/operand_forward_unit.sv
// ID-stage operand bypass: resolves each read channel from x0, pipeline stages,
// a returning long-latency result or the register file, stalling on unready producers.
module operand_forward_unit
    import operand_forward_unit_pkg::*;
#(
    parameter int NUM_RD_CH  = 2,
    parameter int NUM_STAGES = 3,
    parameter int XLEN       = XLEN_DEF,
    parameter int RA_W       = RA_W_DEF,
    parameter int SB_CNT_W   = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_RD_CH-1:0]       id_rd_valid,
    input  logic [NUM_RD_CH*RA_W-1:0]  id_rd_addr,
    output logic [NUM_RD_CH*XLEN-1:0]  id_rd_data,
    output logic                       id_stall,
    input  logic [NUM_STAGES-1:0]      stage_dest_valid,
    input  logic [NUM_STAGES-1:0]      stage_dest_ready,
    input  logic [NUM_STAGES*RA_W-1:0] stage_dest_addr,
    input  logic [NUM_STAGES*XLEN-1:0] stage_dest_data,
    input  logic                       lat_issue_valid,
    input  logic [RA_W-1:0]            lat_issue_addr,
    output logic                       lat_issue_ready,
    input  logic                       lat_done_valid,
    input  logic [RA_W-1:0]            lat_done_addr,
    input  logic [XLEN-1:0]            lat_done_data,
    output logic [NUM_RD_CH-1:0]       register_rd_en,
    output logic [NUM_RD_CH*RA_W-1:0]  register_rd_addr,
    input  logic [NUM_RD_CH*XLEN-1:0]  register_rd_data,
    output logic                       sb_err
);

    localparam int NREG = 1 << RA_W;

    logic [NREG-1:0]      pending;
    logic [NUM_RD_CH-1:0] ch_stall;

    fwd_scoreboard #(
        .RA_W     (RA_W),
        .SB_CNT_W (SB_CNT_W)
    ) u_scoreboard (
        .clk             (clk),
        .reset_n         (reset_n),
        .lat_issue_valid (lat_issue_valid),
        .lat_issue_addr  (lat_issue_addr),
        .lat_issue_ready (lat_issue_ready),
        .lat_done_valid  (lat_done_valid),
        .lat_done_addr   (lat_done_addr),
        .pending         (pending),
        .sb_err          (sb_err)
    );

    for (genvar c = 0; c < NUM_RD_CH; c++) begin : g_ch
        logic [RA_W-1:0]       rd_addr;
        logic [MAX_STAGES-1:0] hit;
        stage_sel_t            sel;
        logic [XLEN-1:0]       stg_data;
        logic                  stg_ready;
        fwd_src_e              src;
        logic [XLEN-1:0]       data;

        assign rd_addr = id_rd_addr[c*RA_W +: RA_W];

        always_comb begin
            hit = '0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                hit[s] = stage_dest_valid[s] &&
                         (stage_dest_addr[s*RA_W +: RA_W] == rd_addr) &&
                         (stage_dest_addr[s*RA_W +: RA_W] != '0);
            end
            sel = stage_select(hit);

            stg_data  = '0;
            stg_ready = 1'b0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (sel.found && (sel.idx == STAGE_IDX_W'(s))) begin
                    stg_data  = stage_dest_data[s*XLEN +: XLEN];
                    stg_ready = stage_dest_ready[s];
                end
            end

            // The youngest match is authoritative: an unready one stalls rather than falling back to older stages.
            if (rd_addr == '0) begin
                src = SRC_ZERO;
            end else if (sel.found) begin
                src = stg_ready ? SRC_STAGE : SRC_STALL;
            end else if (lat_done_valid && (lat_done_addr == rd_addr)) begin
                src = SRC_LAT;
            end else if (pending[rd_addr]) begin
                src = SRC_STALL;
            end else begin
                src = SRC_RF;
            end
        end

        always_comb begin
            data = '0;
            case (src)
                SRC_STAGE: data = stg_data;
                SRC_LAT:   data = lat_done_data;
                SRC_RF:    data = register_rd_data[c*XLEN +: XLEN];
                default:   data = '0;
            endcase
        end

        assign id_rd_data[c*XLEN +: XLEN]       = id_rd_valid[c] ? data : '0;
        assign register_rd_addr[c*RA_W +: RA_W] = rd_addr;
        assign register_rd_en[c]                = id_rd_valid[c] && (src == SRC_RF);
        assign ch_stall[c]                      = (src == SRC_STALL);
    end

    assign id_stall = |(ch_stall & id_rd_valid);

endmodule
